// File: rtl/store_rmw_ctrl_pkg.sv
// Shared definitions for the store read-merge-write sequencer: opcodes,
// FSM state encoding and the request legality rule.
package store_pkg;

    localparam logic [1:0] OP_SB   = 2'b00;
    localparam logic [1:0] OP_SH   = 2'b01;
    localparam logic [1:0] OP_SW   = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CAPT  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } state_t;

    // Misaligned halfword/word stores and the reserved opcode are rejected.
    function automatic logic is_illegal(input logic [1:0] op, input logic [1:0] addr_lo);
        logic bad;
        case (op)
            OP_SB:   bad = 1'b0;
            OP_SH:   bad = addr_lo[0];
            OP_SW:   bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_rmw_ctrl_if.sv
// Request and data-memory bus of the store sequencer; slave is the controller side.
interface store_rmw_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rdata;
    logic              mem_wr_en;
    logic [31:0]       mem_wdata;
    logic              done;
    logic              err;
    logic              busy;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
        output req_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wdata, done, err, busy
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, mem_rdata,
        input  req_ready, mem_rd_en, mem_addr, mem_wr_en, mem_wdata, done, err, busy
    );
endinterface

// File: rtl/store_rmw_ctrl_byte_lane_merge.sv
// Splices a byte or halfword into a 32-bit word read from memory.
// Opcodes other than SB/SH pass the original word through.
module byte_lane_merge
    import store_pkg::*;
(
    input  logic [31:0] origin,
    input  logic [15:0] data,
    input  logic [1:0]  op,
    input  logic [1:0]  lane,
    output logic [31:0] merged
);

    // Lane splice: only the addressed byte/halfword is replaced.
    always_comb begin
        merged = origin;
        case (op)
            OP_SB: begin
                case (lane)
                    2'b00:   merged[7:0]   = data[7:0];
                    2'b01:   merged[15:8]  = data[7:0];
                    2'b10:   merged[23:16] = data[7:0];
                    2'b11:   merged[31:24] = data[7:0];
                    default: merged        = origin;
                endcase
            end
            OP_SH: begin
                if (lane[1]) begin
                    merged[31:16] = data;
                end else begin
                    merged[15:0] = data;
                end
            end
            default: merged = origin;
        endcase
    end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store sequencer: SB/SH go through read-merge-write on a synchronous-read
// word memory, SW writes directly, illegal requests are answered with done+err.
module store_rmw_ctrl
    import store_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    store_rmw_if.slave bus
);

    state_t            state_r;
    state_t            next_state_s;
    logic              accept_s;
    logic [1:0]        op_r;
    logic [1:0]        lane_r;
    logic [15:0]       data_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [31:0]       mem_wdata_r;
    logic [31:0]       merged_s;
    logic              ready_r;
    logic              busy_r;
    logic              rd_en_r;
    logic              wr_en_r;
    logic              done_r;
    logic              err_r;
    logic              addr_unused_s;

    // Address bits above the memory range are deliberately ignored.
    assign addr_unused_s = ^bus.req_addr[31:ADDR_W+2];

    assign accept_s = bus.req_valid && ready_r;

    byte_lane_merge u_merge (
        .origin (bus.mem_rdata),
        .data   (data_r),
        .op     (op_r),
        .lane   (lane_r),
        .merged (merged_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    if (is_illegal(bus.req_op, bus.req_addr[1:0])) begin
                        next_state_s = ST_ERR;
                    end else if (bus.req_op == OP_SW) begin
                        next_state_s = ST_WRITE;
                    end else begin
                        next_state_s = ST_READ;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_READ:  next_state_s = ST_CAPT;
            ST_CAPT:  next_state_s = ST_WRITE;
            ST_WRITE: next_state_s = ST_IDLE;
            ST_ERR:   next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
        endcase
    end

    // Control outputs are registered from the next state so they align with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            rd_en_r <= 1'b0;
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            ready_r <= (next_state_s == ST_IDLE);
            busy_r  <= (next_state_s != ST_IDLE);
            rd_en_r <= (next_state_s == ST_READ);
            wr_en_r <= (next_state_s == ST_WRITE);
            done_r  <= (next_state_s == ST_WRITE) || (next_state_s == ST_ERR);
            err_r   <= (next_state_s == ST_ERR);
        end
    end

    // Request latch: held from the accept edge until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r       <= OP_SB;
            lane_r     <= 2'b00;
            data_r     <= 16'h0000;
            mem_addr_r <= '0;
        end else if (accept_s) begin
            op_r       <= bus.req_op;
            lane_r     <= bus.req_addr[1:0];
            data_r     <= bus.req_wdata[15:0];
            mem_addr_r <= bus.req_addr[ADDR_W+1:2];
        end
    end

    // Write word: SW data is taken at accept, partial stores capture the merge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_wdata_r <= 32'h0000_0000;
        end else if (accept_s && (bus.req_op == OP_SW)) begin
            mem_wdata_r <= bus.req_wdata;
        end else if (state_r == ST_CAPT) begin
            mem_wdata_r <= merged_s;
        end
    end

    assign bus.req_ready = ready_r;
    assign bus.busy      = busy_r;
    assign bus.mem_rd_en = rd_en_r;
    assign bus.mem_wr_en = wr_en_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.done      = done_r;
    assign bus.err       = err_r;

endmodule

// File: tb/tb_store_rmw_ctrl.sv
// Bench for store_rmw_ctrl: word memory, latency/merge reference model with
// per-cycle comparison, and directed stores with hand-computed results.
module tb_store_rmw_ctrl;

    localparam int AW = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    store_rmw_if #(.ADDR_W(AW)) bus ();

    store_rmw_ctrl #(.ADDR_W(AW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Data memory: synchronous read, write on strobe.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (bus.mem_wr_en) mem[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Reference model: what each accepted request must produce and when.
    logic [31:0] ref_mem [0:(1<<AW)-1];
    int          m_phase;
    int          m_last;
    logic        m_partial;
    logic        m_bad;
    logic [AW-1:0] m_addr;
    logic [31:0] m_word;

    function automatic logic [31:0] model_merge(input logic [1:0] op, input logic [31:0] a,
                                                input logic [31:0] wd, input logic [31:0] old);
        int sh;
        logic [31:0] mask;
        if (op == 2'b00) begin
            sh = 8 * int'(a[1:0]);
            mask = 32'h0000_00FF << sh;
        end else begin
            sh = 16 * int'(a[1]);
            mask = 32'h0000_FFFF << sh;
        end
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0;
            m_last <= 1;
            m_partial <= 1'b0;
            m_bad <= 1'b0;
            m_addr <= '0;
            m_word <= 32'h0;
        end else if (m_phase == 0) begin
            if (bus.req_valid) begin
                logic bad;
                bad = (bus.req_op == 2'b11) || (bus.req_op == 2'b01 && bus.req_addr[0]) ||
                      (bus.req_op == 2'b10 && bus.req_addr[1:0] != 2'b00);
                m_bad <= bad;
                m_partial <= !bad && (bus.req_op != 2'b10);
                m_last <= (!bad && bus.req_op != 2'b10) ? 3 : 1;
                m_addr <= bus.req_addr[AW+1:2];
                m_word <= (bus.req_op == 2'b10) ? bus.req_wdata :
                          model_merge(bus.req_op, bus.req_addr, bus.req_wdata, ref_mem[bus.req_addr[AW+1:2]]);
                m_phase <= 1;
            end
        end else if (m_phase == m_last) begin
            if (!m_bad) ref_mem[m_addr] <= m_word;
            m_phase <= 0;
        end else begin
            m_phase <= m_phase + 1;
        end
    end

    // Per-cycle comparison of every output against the model.
    logic e_act, e_rd, e_wr, e_done, e_err;
    always @(negedge clk) begin
        e_act  = (m_phase != 0);
        e_rd   = e_act && m_partial && (m_phase == 1);
        e_done = e_act && (m_phase == m_last);
        e_wr   = e_done && !m_bad;
        e_err  = e_done && m_bad;
        chk("req_ready", {31'b0, bus.req_ready}, {31'b0, !e_act});
        chk("busy", {31'b0, bus.busy}, {31'b0, e_act});
        chk("mem_rd_en", {31'b0, bus.mem_rd_en}, {31'b0, e_rd});
        chk("mem_wr_en", {31'b0, bus.mem_wr_en}, {31'b0, e_wr});
        chk("done", {31'b0, bus.done}, {31'b0, e_done});
        chk("err", {31'b0, bus.err}, {31'b0, e_err});
        chk("mem_addr", {22'b0, bus.mem_addr}, {22'b0, m_addr});
        if (e_wr) chk("mem_wdata", bus.mem_wdata, m_word);
    end

    // One request; returns after done (or a bounded timeout) and pins latency and data.
    task automatic do_req(input string name, input logic [1:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input int exp_lat, input int exp_rd_cyc,
                          input logic exp_err, input logic [31:0] exp_word);
        int lat = 0;
        int rd_cyc = 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op = op;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_wdata = 32'hFFFF_FFFF;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.mem_rd_en && rd_cyc == 0) begin
                rd_cyc = i;
                chk({name, "_rd_addr"}, {22'b0, bus.mem_addr}, {22'b0, addr[AW+1:2]});
            end
            if (bus.done) begin
                lat = i;
                chk({name, "_err"}, {31'b0, bus.err}, {31'b0, exp_err});
                if (!exp_err) chk({name, "_wdata"}, bus.mem_wdata, exp_word);
                break;
            end
        end
        chk({name, "_latency"}, lat, exp_lat);
        chk({name, "_rd_cycle"}, rd_cyc, exp_rd_cyc);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_ready"}, {31'b0, bus.req_ready}, 32'd1);
        chk({name, "_busy"}, {31'b0, bus.busy}, 32'd0);
        chk({name, "_rd"}, {31'b0, bus.mem_rd_en}, 32'd0);
        chk({name, "_wr"}, {31'b0, bus.mem_wr_en}, 32'd0);
        chk({name, "_done"}, {31'b0, bus.done}, 32'd0);
        chk({name, "_err"}, {31'b0, bus.err}, 32'd0);
        chk({name, "_addr"}, {22'b0, bus.mem_addr}, 32'd0);
        chk({name, "_wdata"}, bus.mem_wdata, 32'd0);
    endtask

    initial begin
        int d1;
        int d2;
        bus.req_valid = 1'b0;
        bus.req_op = 2'b00;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_req("sw_init", 2'b10, 32'h14, 32'h1122_3344, 1, 0, 1'b0, 32'h1122_3344);
        do_req("sb_lane2", 2'b00, 32'h16, 32'h0000_00AB, 3, 1, 1'b0, 32'h11AB_3344);
        @(negedge clk);
        chk("sb_mem", mem[5], 32'h11AB_3344);

        do_req("sw_pre1", 2'b10, 32'h14, 32'h1122_3344, 1, 0, 1'b0, 32'h1122_3344);
        do_req("sh_hi", 2'b01, 32'h16, 32'h0000_BEEF, 3, 1, 1'b0, 32'hBEEF_3344);
        do_req("sw_pre2", 2'b10, 32'h14, 32'h1122_3344, 1, 0, 1'b0, 32'h1122_3344);
        do_req("sh_lo", 2'b01, 32'h14, 32'h0000_BEEF, 3, 1, 1'b0, 32'h1122_BEEF);

        do_req("sw", 2'b10, 32'h14, 32'hDEAD_BEEF, 1, 0, 1'b0, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("sw_mem", mem[5], 32'hDEAD_BEEF);
        do_req("sw_hiaddr", 2'b10, 32'hFFFF_F014, 32'h0BAD_F00D, 1, 0, 1'b0, 32'h0BAD_F00D);
        @(negedge clk);
        chk("hiaddr_mem", mem[5], 32'h0BAD_F00D);

        do_req("bad_sh", 2'b01, 32'h15, 32'h0000_1234, 1, 0, 1'b1, 32'h0);
        do_req("bad_sw", 2'b10, 32'h16, 32'h5555_5555, 1, 0, 1'b1, 32'h0);
        do_req("bad_op", 2'b11, 32'h14, 32'h6666_6666, 1, 0, 1'b1, 32'h0);
        @(negedge clk);
        chk("bad_mem", mem[5], 32'h0BAD_F00D);

        // Reset while the merged word is being captured.
        do_req("sw_pre3", 2'b10, 32'h14, 32'h1122_3344, 1, 0, 1'b0, 32'h1122_3344);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op = 2'b00;
        bus.req_addr = 32'h16;
        bus.req_wdata = 32'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_reset_outputs("rst_capt1");
        @(negedge clk);
        chk_reset_outputs("rst_capt2");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mem", mem[5], 32'h1122_3344);
        do_req("sb_after_rst", 2'b00, 32'h14, 32'h0000_0066, 3, 1, 1'b0, 32'h1122_3366);

        // Back-to-back SBs with req_valid held high.
        do_req("sw_pre4", 2'b10, 32'h14, 32'h1122_3344, 1, 0, 1'b0, 32'h1122_3344);
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_op = 2'b00;
        bus.req_addr = 32'h14;
        bus.req_wdata = 32'hAA;
        @(posedge clk); #1;
        bus.req_addr = 32'h17;
        bus.req_wdata = 32'hCD;
        d1 = 0;
        d2 = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 5) bus.req_valid = 1'b0;
            if (bus.done) begin
                if (d1 == 0) begin
                    d1 = i;
                    chk("b2b_word1", bus.mem_wdata, 32'h1122_33AA);
                end else if (d2 == 0) begin
                    d2 = i;
                    chk("b2b_word2", bus.mem_wdata, 32'hCD22_33AA);
                end
            end
            if (d2 != 0) break;
        end
        bus.req_valid = 1'b0;
        chk("b2b_done1_cycle", d1, 3);
        chk("b2b_done2_cycle", d2, 7);
        @(negedge clk);
        chk("b2b_mem", mem[5], 32'hCD22_33AA);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
